// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus port: FSM state encoding and
// default widths / timeout used by mem_bus_port and mem_bus_fsm.
package mem_bus_pkg;

  localparam int DEF_DATA_W         = 16;
  localparam int DEF_ADDR_W         = 16;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

endpackage

// File: rtl/mem_bus_fsm.sv
// Transaction sequencer for mem_bus_port: IDLE -> REQ -> RELEASE -> FINISH,
// 4-phase req/ack handshake with external memory.
// Optional macro MEM_TIMEOUT_EN adds a REQ-phase timeout that aborts to
// FINISH and raises a sticky ERR flag.
module mem_bus_fsm
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic MEM_READ,
  input  logic MEM_WRITE,
  input  logic MEM_ACK,
  output logic idle,
  output logic rd_capture,
  output logic MEM_REQ,
  output logic MEM_WE,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  state_t state;
  state_t state_nxt;
  logic   start;
  logic   we_q;
  logic   tmo_hit;

  assign idle       = (state == ST_IDLE);
  assign start      = idle && (MEM_READ || MEM_WRITE);
  assign MEM_REQ    = (state == ST_REQ);
  assign MEM_WE     = we_q;
  assign BUSY       = (state == ST_REQ) || (state == ST_RELEASE);
  assign DONE       = (state == ST_FINISH);
  // Read data is taken in the same cycle the ack is seen in REQ
  assign rd_capture = (state == ST_REQ) && MEM_ACK && !we_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // The cycle that would bring the count up to TIMEOUT_CYCLES ends REQ
  assign tmo_hit = (state == ST_REQ) && !MEM_ACK &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ERR     = err_q;

  // Count unacknowledged REQ cycles; held at zero while idle so it is clear on entry
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tmo_cnt <= '0;
    end else if (state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else if ((state == ST_REQ) && !MEM_ACK) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Sticky timeout flag, cleared by the next transaction start
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign ERR        = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Next-state logic for the handshake sequence
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (MEM_READ || MEM_WRITE) state_nxt = ST_REQ;
      ST_REQ: begin
        if (MEM_ACK)      state_nxt = ST_RELEASE;
        else if (tmo_hit) state_nxt = ST_FINISH;
      end
      ST_RELEASE: if (!MEM_ACK) state_nxt = ST_FINISH;
      ST_FINISH:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register; async reset drops MEM_REQ immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Direction latch: read wins when both start pulses arrive together
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)      we_q <= 1'b0;
    else if (start) we_q <= !MEM_READ;
  end

endmodule

// File: rtl/mem_bus_port.sv
// Memory-side endpoint of the shared CPU bus: MAR/MDR capture from BUS,
// req/ack memory transaction via mem_bus_fsm, tri-stated MDR drive back
// onto the bus. Optional macro MEM_TIMEOUT_EN enables the REQ timeout.
module mem_bus_port
  import mem_bus_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] BUS,
  output logic [DATA_W-1:0] MDR_OUT,
  input  logic              MAR_LOAD,
  input  logic              MDR_LOAD,
  input  logic              MDR_BUS,
  input  logic              MEM_READ,
  input  logic              MEM_WRITE,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] MDR_TOCPU,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  output logic              MEM_REQ,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              ERR
);

  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              idle;
  logic              rd_capture;

  mem_bus_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .CLK        (CLK),
    .RESET      (RESET),
    .MEM_READ   (MEM_READ),
    .MEM_WRITE  (MEM_WRITE),
    .MEM_ACK    (MEM_ACK),
    .idle       (idle),
    .rd_capture (rd_capture),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  // MAR loads only while idle; upper bus bits beyond ADDR_W are dropped
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                 mar <= '0;
    else if (idle && MAR_LOAD) mar <= BUS[ADDR_W-1:0];
  end

  // MDR loads from the bus while idle, or from memory on a read ack
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                 mdr <= '0;
    else if (rd_capture)       mdr <= MEM_RDATA;
    else if (idle && MDR_LOAD) mdr <= BUS;
  end

  assign MEM_ADDR  = mar;
  assign MEM_WDATA = mdr;
  assign MDR_TOCPU = mdr;
  assign MDR_OUT   = MDR_BUS ? mdr : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_port.sv
// Scoreboard bench for mem_bus_port: stimulus pushes the expected
// completion (MDR, ERR) at each transaction start; a monitor pops and
// compares on every DONE pulse. A small memory model answers REQ.
module tb_mem_bus_port;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] BUS;
  wire  [15:0] MDR_OUT;
  logic        MAR_LOAD, MDR_LOAD, MDR_BUS, MEM_READ, MEM_WRITE;
  logic        BUSY, DONE, MEM_WE, MEM_REQ, ERR;
  logic [15:0] MDR_TOCPU, MEM_ADDR, MEM_WDATA;
  logic [15:0] MEM_RDATA;
  logic        MEM_ACK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] mdr;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // memory model controls
  int          ack_delay = 3;
  logic        ack_never = 1'b0;
  logic [15:0] rd_value  = 16'h0000;
  int          dly;
  logic [15:0] mem [0:255];

  mem_bus_port dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUS       (BUS),
    .MDR_OUT   (MDR_OUT),
    .MAR_LOAD  (MAR_LOAD),
    .MDR_LOAD  (MDR_LOAD),
    .MDR_BUS   (MDR_BUS),
    .MEM_READ  (MEM_READ),
    .MEM_WRITE (MEM_WRITE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .MDR_TOCPU (MDR_TOCPU),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_WE    (MEM_WE),
    .MEM_REQ   (MEM_REQ),
    .MEM_RDATA (MEM_RDATA),
    .MEM_ACK   (MEM_ACK),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  // Memory model: ack after ack_delay REQ cycles, drop ack once REQ falls
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_ACK   <= 1'b0;
      MEM_RDATA <= 16'h0000;
      dly       <= 0;
    end else if (MEM_REQ && !MEM_ACK) begin
      if (!ack_never && dly >= ack_delay - 1) begin
        MEM_ACK   <= 1'b1;
        MEM_RDATA <= rd_value;
        if (MEM_WE) mem[MEM_ADDR[7:0]] <= MEM_WDATA;
        dly <= 0;
      end else begin
        dly <= dly + 1;
      end
    end else if (!MEM_REQ) begin
      MEM_ACK <= 1'b0;
      dly     <= 0;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest expected completion
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got DONE=1 expected no completion");
        end else begin
          e = sb_q.pop_front();
          check("done_mdr", MDR_TOCPU, e.mdr);
          check("done_err", {15'b0, ERR}, {15'b0, e.err});
        end
      end
    end
  end

  task automatic expect_txn(input logic [15:0] mdr, input logic err);
    exp_t e;
    e.mdr = mdr;
    e.err = err;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge where the FSM is idle again
  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (DONE !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (DONE !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no DONE within %0d cycles expected DONE", name, budget);
    end else begin
      check({name, "_busy_in_finish"}, {15'b0, BUSY}, 16'h0000);
      @(negedge CLK);
      check({name, "_done_single"}, {15'b0, DONE}, 16'h0000);
    end
  endtask

  task automatic load(input logic mar, input logic mdr, input logic [15:0] val);
    BUS = val; MAR_LOAD = mar; MDR_LOAD = mdr;
    @(negedge CLK);
    MAR_LOAD = 1'b0; MDR_LOAD = 1'b0;
  endtask

  task automatic start(input logic rd, input logic wr);
    MEM_READ = rd; MEM_WRITE = wr;
    @(negedge CLK);
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
  endtask

  initial begin
    int req_cycles;
    RESET = 1'b1; BUS = 16'h0000;
    MAR_LOAD = 1'b0; MDR_LOAD = 1'b0; MDR_BUS = 1'b0;
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    #12;
    // reset state
    check("rst_req",  {15'b0, MEM_REQ}, 16'h0000);
    check("rst_busy", {15'b0, BUSY},    16'h0000);
    check("rst_done", {15'b0, DONE},    16'h0000);
    check("rst_we",   {15'b0, MEM_WE},  16'h0000);
    check("rst_err",  {15'b0, ERR},     16'h0000);
    check("rst_mdr",  MDR_TOCPU, 16'h0000);
    check("rst_mar",  MEM_ADDR,  16'h0000);
    n_checks++;
    if (!(MDR_OUT === 16'hzzzz)) begin
      n_fail++;
      $display("FAIL rst_mdr_out_z: got %h expected zzzz", MDR_OUT);
    end
    MDR_BUS = 1'b1;
    #1 check("rst_mdr_out_drive", MDR_OUT, 16'h0000);
    MDR_BUS = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // read 0x0040 -> BEEF
    load(1'b1, 1'b0, 16'h0040);
    rd_value = 16'hBEEF;
    expect_txn(16'hBEEF, 1'b0);
    start(1'b1, 1'b0);
    check("rd_req",  {15'b0, MEM_REQ}, 16'h0001);
    check("rd_busy", {15'b0, BUSY},    16'h0001);
    check("rd_addr", MEM_ADDR, 16'h0040);
    check("rd_we",   {15'b0, MEM_WE},  16'h0000);
    wait_done("rd", 30);
    MDR_BUS = 1'b1;
    #1 check("rd_mdr_out", MDR_OUT, 16'hBEEF);
    MDR_BUS = 1'b0;
    #1;
    n_checks++;
    if (!(MDR_OUT === 16'hzzzz)) begin
      n_fail++;
      $display("FAIL mdr_out_z: got %h expected zzzz", MDR_OUT);
    end
    @(negedge CLK);

    // write A5A5 to 0x0012
    load(1'b1, 1'b0, 16'h0012);
    load(1'b0, 1'b1, 16'hA5A5);
    expect_txn(16'hA5A5, 1'b0);
    start(1'b0, 1'b1);
    check("wr_we",    {15'b0, MEM_WE}, 16'h0001);
    check("wr_wdata", MEM_WDATA, 16'hA5A5);
    check("wr_addr",  MEM_ADDR,  16'h0012);
    @(negedge CLK);
    check("wr_we_hold",    {15'b0, MEM_WE}, 16'h0001);
    check("wr_wdata_hold", MEM_WDATA, 16'hA5A5);
    wait_done("wr", 30);
    check("wr_mem", mem[8'h12], 16'hA5A5);

    // busy lockout: strobes and start during REQ are ignored
    rd_value = 16'h1234;
    expect_txn(16'h1234, 1'b0);
    start(1'b1, 1'b0);
    BUS = 16'hFFFF; MAR_LOAD = 1'b1; MDR_LOAD = 1'b1; MEM_WRITE = 1'b1;
    @(negedge CLK);
    MAR_LOAD = 1'b0; MDR_LOAD = 1'b0; MEM_WRITE = 1'b0;
    check("lock_addr", MEM_ADDR, 16'h0012);
    check("lock_we",   {15'b0, MEM_WE}, 16'h0000);
    check("lock_busy", {15'b0, BUSY},   16'h0001);
    wait_done("lock", 30);
    repeat (4) @(negedge CLK);
    check("lock_no_second", {15'b0, BUSY}, 16'h0000);

    // read wins when both starts pulse together
    rd_value = 16'h5A5A;
    expect_txn(16'h5A5A, 1'b0);
    start(1'b1, 1'b1);
    check("prio_we", {15'b0, MEM_WE}, 16'h0000);
    wait_done("prio", 30);

    // MDR_BUS with MDR_LOAD: old value on bus until the edge
    BUS = 16'h1111; MDR_BUS = 1'b1; MDR_LOAD = 1'b1;
    #1 check("bus_load_old", MDR_OUT, 16'h5A5A);
    @(posedge CLK);
    #1 check("bus_load_new", MDR_OUT, 16'h1111);
    @(negedge CLK);
    MDR_BUS = 1'b0; MDR_LOAD = 1'b0;

    // async reset mid-REQ, then a normal read
    ack_delay = 10;
    start(1'b1, 1'b0);
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    check("arst_req",  {15'b0, MEM_REQ}, 16'h0000);
    check("arst_busy", {15'b0, BUSY},    16'h0000);
    check("arst_mdr",  MDR_TOCPU, 16'h0000);
    @(negedge CLK);
    RESET = 1'b0;
    ack_delay = 3;
    @(negedge CLK);
    load(1'b1, 1'b0, 16'h0040);
    rd_value = 16'hBEEF;
    expect_txn(16'hBEEF, 1'b0);
    start(1'b1, 1'b0);
    check("post_rst_addr", MEM_ADDR, 16'h0040);
    wait_done("post_rst", 30);

`ifdef MEM_TIMEOUT_EN
    // timeout: no ack ever, abort after 15 REQ cycles
    ack_never = 1'b1;
    expect_txn(16'hBEEF, 1'b1);
    MEM_READ = 1'b1;
    @(negedge CLK);
    MEM_READ = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40 && DONE !== 1'b1; i++) begin
      if (MEM_REQ === 1'b1) req_cycles++;
      @(negedge CLK);
    end
    check("tmo_req_cycles", 16'(req_cycles), 16'd15);
    wait_done("tmo", 5);
    check("tmo_err_sticky", {15'b0, ERR}, 16'h0001);
    ack_never = 1'b0;
    rd_value = 16'h7777;
    expect_txn(16'h7777, 1'b0);
    start(1'b1, 1'b0);
    check("tmo_err_clear", {15'b0, ERR}, 16'h0000);
    wait_done("tmo_next", 30);
`else
    req_cycles = 0;
    check("no_tmo_err", {15'b0, ERR}, 16'(req_cycles));
`endif

    repeat (3) @(negedge CLK);
    check("sb_empty", 16'(sb_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
